// File: rtl/countdown_timer.sv
// MM:SS BCD countdown timer with IDLE/RUN/PAUSE/EXPIRED control FSM.
// It decrements one second per external tick while in RUN.
module countdown_timer (
  input  logic       clk,
  input  logic       reset,
  input  logic       tick,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic       clear_alarm,
  input  logic [2:0] d_min_t,
  input  logic [3:0] d_min_o,
  input  logic [2:0] d_sec_t,
  input  logic [3:0] d_sec_o,
  output logic [2:0] q_min_t,
  output logic [3:0] q_min_o,
  output logic [2:0] q_sec_t,
  output logic [3:0] q_sec_o,
  output logic       running,
  output logic       expired,
  output logic       done
);

  localparam int unsigned TW = 3;
  localparam int unsigned OW = 4;

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

  state_t        state, state_nxt;
  logic [TW-1:0] min_t_nxt, sec_t_nxt;
  logic [OW-1:0] min_o_nxt, sec_o_nxt;
  logic          done_nxt;

  logic [TW-1:0] ld_min_t, ld_sec_t, dec_min_t, dec_sec_t;
  logic [OW-1:0] ld_min_o, ld_sec_o, dec_min_o, dec_sec_o;
  logic          borrow_sec_o, borrow_sec_t, borrow_min_o;
  logic          count_zero, last_sec;

  // Preset digits are clamped independently so the count never exceeds 59:59.
  assign ld_min_t = (d_min_t > TW'(5)) ? TW'(5) : d_min_t;
  assign ld_min_o = (d_min_o > OW'(9)) ? OW'(9) : d_min_o;
  assign ld_sec_t = (d_sec_t > TW'(5)) ? TW'(5) : d_sec_t;
  assign ld_sec_o = (d_sec_o > OW'(9)) ? OW'(9) : d_sec_o;

  // One-second BCD decrement with borrow rippling from seconds-ones upward.
  assign borrow_sec_o = (q_sec_o == OW'(0));
  assign borrow_sec_t = borrow_sec_o && (q_sec_t == TW'(0));
  assign borrow_min_o = borrow_sec_t && (q_min_o == OW'(0));

  assign dec_sec_o = borrow_sec_o ? OW'(9) : q_sec_o - OW'(1);
  assign dec_sec_t = !borrow_sec_o ? q_sec_t :
                     (borrow_sec_t ? TW'(5) : q_sec_t - TW'(1));
  assign dec_min_o = !borrow_sec_t ? q_min_o :
                     (borrow_min_o ? OW'(9) : q_min_o - OW'(1));
  assign dec_min_t = borrow_min_o ? q_min_t - TW'(1) : q_min_t;

  assign count_zero = (q_min_t == TW'(0)) && (q_min_o == OW'(0)) &&
                      (q_sec_t == TW'(0)) && (q_sec_o == OW'(0));
  assign last_sec   = (q_min_t == TW'(0)) && (q_min_o == OW'(0)) &&
                      (q_sec_t == TW'(0)) && (q_sec_o == OW'(1));

  // Next-state and next-count decode; stop outranks tick, load outranks start.
  always_comb begin
    state_nxt = state;
    min_t_nxt = q_min_t;
    min_o_nxt = q_min_o;
    sec_t_nxt = q_sec_t;
    sec_o_nxt = q_sec_o;
    done_nxt  = 1'b0;
    case (state)
      IDLE, PAUSE: begin
        if (load) begin
          state_nxt = IDLE;
          min_t_nxt = ld_min_t;
          min_o_nxt = ld_min_o;
          sec_t_nxt = ld_sec_t;
          sec_o_nxt = ld_sec_o;
        end else if (start && !count_zero) begin
          state_nxt = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_nxt = PAUSE;
        end else if (tick) begin
          min_t_nxt = dec_min_t;
          min_o_nxt = dec_min_o;
          sec_t_nxt = dec_sec_t;
          sec_o_nxt = dec_sec_o;
          if (last_sec) begin
            state_nxt = EXPIRED;
            done_nxt  = 1'b1;
          end
        end
      end
      EXPIRED: begin
        if (clear_alarm) begin
          state_nxt = IDLE;
          min_t_nxt = '0;
          min_o_nxt = '0;
          sec_t_nxt = '0;
          sec_o_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, count and status flags; flags decode the next state so they track state exactly.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      q_min_t <= '0;
      q_min_o <= '0;
      q_sec_t <= '0;
      q_sec_o <= '0;
      running <= 1'b0;
      expired <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      q_min_t <= min_t_nxt;
      q_min_o <= min_o_nxt;
      q_sec_t <= sec_t_nxt;
      q_sec_o <= sec_o_nxt;
      running <= (state_nxt == RUN);
      expired <= (state_nxt == EXPIRED);
      done    <= done_nxt;
    end
  end

endmodule
